cp0_exc_ctrl: RTL and testbench

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

---
 rtl/cp0_exc_ctrl.sv | 121 ++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC and PRId, plus the entry/return sequencer.
// Optional build macro CP0_EXC_CNT_EN adds a read-only exception counter at register 16.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE   = 32'h2020_1210
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    output logic [31:0] RD,
    input  logic [4:0]  A2,
    input  logic [31:0] WD,
    input  logic        WE,
    input  logic [31:0] PCAddr,
    input  logic        BDIn,
    input  logic        ExcValid,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EretIn,
    output logic        IntReq,
    output logic [31:0] HandlerPC,
    output logic [31:0] EPCOut,
    output logic        InHandler
);

    typedef enum logic [1:0] {RUN, ENTER, HANDLER, RETURN} state_t;

    state_t      state, state_nxt;
    logic [5:0]  sr_im;
    logic        sr_exl, sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_code;
    logic [31:0] epc;
    logic [31:0] epc_take;
    logic [31:0] cnt_rd;
    logic        intpend, exctake;
    logic        sr_wr, epc_wr;

    always_comb begin
        intpend   = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
        exctake   = ExcValid & ~sr_exl;
        IntReq    = (state == RUN) & (intpend | exctake);
        sr_wr     = WE & ~IntReq & (A2 == 5'd12);
        epc_wr    = WE & ~IntReq & (A2 == 5'd14);
        epc_take  = (BDIn ? (PCAddr - 32'd4) : PCAddr) & 32'hFFFF_FFFC;
        state_nxt = state;
        case (state)
            RUN:     if (IntReq) state_nxt = ENTER;
            ENTER:   state_nxt = HANDLER;
            // eret wins over an mtc0 that drops EXL in the same cycle
            HANDLER: if (EretIn) state_nxt = RETURN;
                     else if (sr_wr && !WD[1]) state_nxt = RUN;
            RETURN:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im      <= '0;
            sr_exl     <= 1'b0;
            sr_ie      <= 1'b0;
            cause_bd   <= 1'b0;
            cause_ip   <= '0;
            cause_code <= '0;
            epc        <= '0;
        end else begin
            cause_ip <= HWInt;
            if (IntReq) begin
                sr_exl     <= 1'b1;
                cause_bd   <= BDIn;
                cause_code <= intpend ? 5'd0 : ExcCodeIn;
                epc        <= epc_take;
            end else begin
                if (sr_wr) begin
                    sr_im  <= WD[15:10];
                    sr_exl <= WD[1];
                    sr_ie  <= WD[0];
                end
                if (epc_wr) epc <= {WD[31:2], 2'b00};
                if (state == HANDLER && EretIn) sr_exl <= 1'b0;
            end
        end
    end

`ifdef CP0_EXC_CNT_EN
    logic [31:0] exccnt;

    always_ff @(posedge clk) begin
        if (reset)       exccnt <= '0;
        else if (IntReq) exccnt <= exccnt + 32'd1;
    end

    assign cnt_rd = exccnt;
`else
    assign cnt_rd = '0;
`endif

    always_comb begin
        RD = '0;
        case (A1)
            5'd12:   RD = {16'h0000, sr_im, 8'h00, sr_exl, sr_ie};
            5'd13:   RD = {cause_bd, 15'h0000, cause_ip, 3'b000, cause_code, 2'b00};
            5'd14:   RD = epc;
            5'd15:   RD = PRID_VALUE;
            5'd16:   RD = cnt_rd;
            default: RD = '0;
        endcase
    end

    assign HandlerPC = HANDLER_ADDR;
    assign EPCOut    = epc;
    assign InHandler = (state == ENTER) || (state == HANDLER);

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed vector table, then random stimulus against a register-level model.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, ExcCodeIn;
    logic [31:0] RD, WD, PCAddr, HandlerPC, EPCOut;
    logic        WE, BDIn, ExcValid, EretIn, IntReq, InHandler;
    logic [5:0]  HWInt;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .A1(A1), .RD(RD), .A2(A2), .WD(WD), .WE(WE),
        .PCAddr(PCAddr), .BDIn(BDIn), .ExcValid(ExcValid), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .EretIn(EretIn), .IntReq(IntReq), .HandlerPC(HandlerPC),
        .EPCOut(EPCOut), .InHandler(InHandler)
    );

`ifdef CP0_EXC_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic        rst, we;
        logic [4:0]  a2;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [5:0]  hw;
        logic        ev;
        logic [4:0]  ec;
        logic        bd;
        logic [31:0] pc;
        logic        eret, chk, xi, xh;
        logic [31:0] xrd, xepc;
    } vec_t;

    int errs = 0;
    int nchk = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] a2,
                                input logic [31:0] wd, input logic [4:0] a1, input logic [5:0] hw,
                                input logic ev, input logic [4:0] ec, input logic bd,
                                input logic [31:0] pc, input logic eret, input logic chk,
                                input logic xi, input logic xh, input logic [31:0] xrd,
                                input logic [31:0] xepc);
        vec_t v;
        v.rst = rst; v.we = we; v.a2 = a2; v.wd = wd; v.a1 = a1; v.hw = hw;
        v.ev = ev; v.ec = ec; v.bd = bd; v.pc = pc; v.eret = eret; v.chk = chk;
        v.xi = xi; v.xh = xh; v.xrd = xrd; v.xepc = xepc;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; WE = v.we; A2 = v.a2; WD = v.wd; A1 = v.a1; HWInt = v.hw;
        ExcValid = v.ev; ExcCodeIn = v.ec; BDIn = v.bd; PCAddr = v.pc; EretIn = v.eret;
    endtask

    // Architectural model: whole 32-bit register images plus handler phase
    // (0 running, 1 entering, 2 in handler, 3 returning).
    logic [31:0] m_sr, m_cause, m_epc, m_cnt;
    int          m_phase;

    function automatic logic m_irq(input logic [5:0] hw, input logic ev);
        logic ip;
        ip = (|(hw & m_sr[15:10])) && m_sr[0] && !m_sr[1];
        return (m_phase == 0) && (ip || (ev && !m_sr[1]));
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a1);
        case (a1)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h2020_1210;
            5'd16:   return CNT_EN ? m_cnt : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step(input vec_t v);
        logic irq, ipend, leave;
        irq   = m_irq(v.hw, v.ev);
        ipend = (|(v.hw & m_sr[15:10])) && m_sr[0] && !m_sr[1];
        leave = 1'b0;
        if (v.rst) begin
            m_sr = 0; m_cause = 0; m_epc = 0; m_cnt = 0; m_phase = 0;
        end else begin
            if (irq) begin
                m_sr    = m_sr | 32'h2;
                m_cause = {v.bd, 31'h0} | (32'(ipend ? 5'd0 : v.ec) << 2);
                m_epc   = (v.bd ? v.pc - 32'd4 : v.pc) & 32'hFFFF_FFFC;
                m_cnt   = m_cnt + 1;
                m_phase = 1;
            end else begin
                if (v.we && v.a2 == 5'd12) begin
                    m_sr = v.wd & 32'h0000_FC03;
                    leave = !v.wd[1];
                end
                if (v.we && v.a2 == 5'd14) m_epc = v.wd & 32'hFFFF_FFFC;
                if (m_phase == 2 && v.eret) begin
                    m_sr = m_sr & ~32'h2;
                    m_phase = 3;
                end else if (m_phase == 2 && leave) m_phase = 0;
                else if (m_phase == 1) m_phase = 2;
                else if (m_phase == 3) m_phase = 0;
            end
            m_cause = (m_cause & ~32'h0000_FC00) | (32'(v.hw) << 10);
        end
    endtask

    initial begin
        logic [31:0] cnt3;
        cnt3 = CNT_EN ? 32'd3 : 32'd0;
        // rst we a2 wd a1 hw ev ec bd pc eret | chk irq inh rd epc
        tbl.push_back(mk(1'b1,1'b0,5'd0, 32'h0,       5'd12,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b0,1'b0,1'b0,32'h0,        32'h0));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd12,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'h0,        32'h0));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd15,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'h2020_1210,32'h0));
        tbl.push_back(mk(1'b0,1'b1,5'd12,32'hFC01,    5'd12,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'h0,        32'h0));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd12,6'h01,1'b0,5'd0, 1'b0,32'h100,  1'b0, 1'b1,1'b1,1'b0,32'hFC01,     32'h0));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd13,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b1,32'h400,      32'h100));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd12,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b1, 1'b1,1'b0,1'b1,32'hFC03,     32'h100));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd12,6'h01,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'hFC01,     32'h100));
        tbl.push_back(mk(1'b0,1'b1,5'd12,32'h0,       5'd13,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'h400,      32'h100));
        tbl.push_back(mk(1'b0,1'b1,5'd14,32'h1234,    5'd12,6'h00,1'b1,5'd12,1'b1,32'h3010, 1'b0, 1'b1,1'b1,1'b0,32'h0,        32'h100));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd13,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b1,32'h8000_0030,32'h300C));
        tbl.push_back(mk(1'b0,1'b1,5'd12,32'h0,       5'd14,6'h00,1'b1,5'd3, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b1,32'h300C,     32'h300C));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd12,6'h00,1'b1,5'd4, 1'b0,32'h2000, 1'b0, 1'b1,1'b1,1'b0,32'h0,        32'h300C));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd13,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b1, 1'b1,1'b0,1'b1,32'h10,       32'h2000));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd12,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b1, 1'b1,1'b0,1'b1,32'h2,        32'h2000));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd12,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b1, 1'b1,1'b0,1'b0,32'h0,        32'h2000));
        tbl.push_back(mk(1'b0,1'b1,5'd14,32'h0ABF,    5'd14,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b1, 1'b1,1'b0,1'b0,32'h2000,     32'h2000));
        tbl.push_back(mk(1'b0,1'b1,5'd13,32'hFFFFFFFF,5'd14,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'hABC,      32'hABC));
        tbl.push_back(mk(1'b0,1'b1,5'd15,32'h0,       5'd13,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'h10,       32'hABC));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd16,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,cnt3,         32'hABC));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd1, 6'h00,1'b1,5'd7, 1'b1,32'h2,    1'b0, 1'b1,1'b1,1'b0,32'h0,        32'hABC));
        tbl.push_back(mk(1'b1,1'b0,5'd0, 32'h0,       5'd14,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd14,6'h3F,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'h0,        32'h0));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd13,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'hFC00,     32'h0));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd16,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'h0,        32'h0));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd15,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'h2020_1210,32'h0));
        // Reset taken while in the handler, with a competing mtc0, eret and interrupt
        tbl.push_back(mk(1'b0,1'b1,5'd12,32'hFC01,    5'd12,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'h0,        32'h0));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd12,6'h02,1'b0,5'd0, 1'b0,32'h40,   1'b0, 1'b1,1'b1,1'b0,32'hFC01,     32'h0));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd14,6'h02,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b1,32'h40,       32'h40));
        tbl.push_back(mk(1'b1,1'b1,5'd12,32'hFC03,    5'd12,6'h02,1'b0,5'd0, 1'b0,32'h0,    1'b1, 1'b1,1'b0,1'b1,32'hFC03,     32'h40));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd12,6'h02,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'h0,        32'h0));
        tbl.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       5'd14,6'h00,1'b0,5'd0, 1'b0,32'h0,    1'b0, 1'b1,1'b0,1'b0,32'h0,        32'h0));

        drive(tbl[0]);
        @(posedge clk); #1;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #3;
            if (tbl[i].chk) begin
                check($sformatf("row%0d IntReq", i),    {31'h0, IntReq},    {31'h0, tbl[i].xi});
                check($sformatf("row%0d InHandler", i), {31'h0, InHandler}, {31'h0, tbl[i].xh});
                check($sformatf("row%0d RD", i),        RD,                 tbl[i].xrd);
                check($sformatf("row%0d EPCOut", i),    EPCOut,             tbl[i].xepc);
            end
            @(posedge clk); #1;
        end
        check("HandlerPC", HandlerPC, 32'h0000_4180);

        // Random phase: first cycle forces reset so model and DUT start aligned
        for (int n = 0; n < 1500; n++) begin
            vec_t v;
            int   sel;
            v = mk(1'b0,1'b0,5'd0,32'h0,5'd0,6'h0,1'b0,5'd0,1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0);
            v.rst  = (n == 0) || ($urandom_range(79) == 0);
            v.we   = ($urandom_range(3) == 0);
            sel    = $urandom_range(5);
            v.a2   = (sel == 5) ? 5'($urandom) : 5'(sel + 12);
            v.wd   = $urandom;
            sel    = $urandom_range(5);
            v.a1   = (sel == 5) ? 5'($urandom) : 5'(sel + 12);
            v.hw   = ($urandom_range(3) == 0) ? 6'($urandom) : 6'h0;
            v.ev   = ($urandom_range(5) == 0);
            v.ec   = 5'($urandom);
            v.bd   = 1'($urandom);
            v.pc   = $urandom;
            v.eret = ($urandom_range(2) == 0);
            drive(v);
            #3;
            if (n != 0) begin
                check($sformatf("rnd%0d IntReq", n),    {31'h0, IntReq},    {31'h0, m_irq(v.hw, v.ev)});
                check($sformatf("rnd%0d InHandler", n), {31'h0, InHandler},
                      {31'h0, (m_phase == 1 || m_phase == 2)});
                check($sformatf("rnd%0d RD a1=%0d", n, v.a1), RD, m_rd(v.a1));
                check($sformatf("rnd%0d EPCOut", n),    EPCOut,             m_epc);
            end
            @(posedge clk); #1;
            m_step(v);
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
